line_data_feeder: RTL and testbench

Activation streamer that drives the `i_data`/`i_data_val` side of the line convolution engine in response to its `o_data_req`. It reads a configured run of packed 3-channel pixel words from an on-chip activation memory over a 1-cycle-latency read port, buffers them in a small FIFO, and releases one word per cycle while the engine requests data. Software starts a transfer through the control register and observes completion through `o_busy`/`o_done`.

---
 rtl/line_data_feeder_pkg.sv | 19 +
 rtl/line_data_feeder_sync_fifo.sv | 60 ++++++
 rtl/line_data_feeder.sv | 143 ++++++++++++++
 tb/tb_line_data_feeder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_data_feeder_pkg.sv
// Shared definitions for the line data feeder: FSM encoding, control bit
// positions and default widths.
package line_data_feeder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int CTRL_ENB   = 0;
  localparam int CTRL_START = 1;

  localparam int DEF_BIT_WIDTH   = 8;
  localparam int DEF_NUM_CHANNEL = 3;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_REG_WIDTH   = 32;
  localparam int DEF_FIFO_DEPTH  = 4;

endpackage

// File: rtl/line_data_feeder_sync_fifo.sv
// Small synchronous FIFO with occupancy count and a combinational head output.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/line_data_feeder.sv
// Streams a configured run of packed pixel words from activation memory into
// the line convolution engine, one word per cycle while the engine requests.
module line_data_feeder
  import line_data_feeder_pkg::*;
#(
  parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int NUM_CHANNEL = DEF_NUM_CHANNEL,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int REG_WIDTH   = DEF_REG_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REG_WIDTH-1:0]             i_conf_ctrl,
  input  logic [ADDR_WIDTH-1:0]            i_conf_base_addr,
  input  logic [REG_WIDTH-1:0]             i_conf_num_words,
  input  logic                             i_data_req,
  output logic [BIT_WIDTH*NUM_CHANNEL-1:0] o_data,
  output logic                             o_data_val,
  output logic                             o_mem_en,
  output logic [ADDR_WIDTH-1:0]            o_mem_addr,
  input  logic [BIT_WIDTH*NUM_CHANNEL-1:0] i_mem_data,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int DW = BIT_WIDTH * NUM_CHANNEL;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]            state_q, state_d;
  logic                  start_prev_q, start_prev_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [REG_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [REG_WIDTH-1:0]  deliv_cnt_q, deliv_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [DW-1:0]         data_q, data_d;
  logic                  data_val_q, data_val_d;

  logic                  enb, start_rise, room, issue, streaming, pop_any;
  logic                  fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]         fifo_count, occ;
  logic [DW-1:0]         fifo_head;
  logic                  unused_ctrl;

  assign unused_ctrl = ^i_conf_ctrl[REG_WIDTH-1:CTRL_START+1];

  always_comb begin
    enb        = i_conf_ctrl[CTRL_ENB];
    start_rise = i_conf_ctrl[CTRL_START] & ~start_prev_q;
    // The in-flight read already owns a FIFO slot, so overflow is impossible.
    occ        = fifo_count + CW'(inflight_q);
    room       = (occ < CW'(FIFO_DEPTH));
    issue      = (state_q == ST_RUN) & enb & i_data_req & room;
    streaming  = (state_q == ST_RUN) | (state_q == ST_DRAIN);
    pop_any    = streaming & enb & i_data_req & (~fifo_empty | inflight_q);
    // An arriving word bypasses an empty FIFO straight into the output register.
    fifo_pop   = pop_any & ~fifo_empty;
    fifo_push  = inflight_q & ~(pop_any & fifo_empty);

    data_d     = data_q;
    data_val_d = pop_any;
    if (pop_any) begin
      data_d = fifo_empty ? i_mem_data : fifo_head;
    end

    state_d      = state_q;
    start_prev_d = i_conf_ctrl[CTRL_START];
    ptr_d        = ptr_q;
    issue_cnt_d  = issue_cnt_q;
    deliv_cnt_d  = pop_any ? deliv_cnt_q - REG_WIDTH'(1) : deliv_cnt_q;
    inflight_d   = issue;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          ptr_d       = i_conf_base_addr;
          issue_cnt_d = i_conf_num_words;
          deliv_cnt_d = i_conf_num_words;
          state_d     = (i_conf_num_words == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          ptr_d       = ptr_q + ADDR_WIDTH'(1);
          issue_cnt_d = issue_cnt_q - REG_WIDTH'(1);
          if (issue_cnt_q == REG_WIDTH'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((deliv_cnt_q == '0) && fifo_empty && !inflight_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      ptr_q        <= '0;
      issue_cnt_q  <= '0;
      deliv_cnt_q  <= '0;
      inflight_q   <= 1'b0;
      data_q       <= '0;
      data_val_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      ptr_q        <= ptr_d;
      issue_cnt_q  <= issue_cnt_d;
      deliv_cnt_q  <= deliv_cnt_d;
      inflight_q   <= inflight_d;
      data_q       <= data_d;
      data_val_q   <= data_val_d;
    end
  end

  sync_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (i_mem_data),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign o_data     = data_q;
  assign o_data_val = data_val_q;
  assign o_mem_en   = issue;
  assign o_mem_addr = ptr_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_line_data_feeder.sv
// Scoreboard bench for line_data_feeder: expected words and addresses are
// queued at transfer start and consumed by a monitor as the DUT produces them.
module tb_line_data_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_conf_ctrl;
  logic [15:0] i_conf_base_addr;
  logic [31:0] i_conf_num_words;
  logic        i_data_req;
  logic [23:0] o_data;
  logic        o_data_val;
  logic        o_mem_en;
  logic [15:0] o_mem_addr;
  logic [23:0] i_mem_data = '0;
  logic        o_busy;
  logic        o_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int memen_cnt, val_cnt, done_cnt, busy_cnt;
  int first_val, last_val, done_rel;
  int low_vals = 0;
  int req_mode = 0;
  logic enb_prev = 1'b0;
  logic [23:0] salt = '0;
  logic [23:0] exp_data_q [$];
  logic [15:0] exp_addr_q [$];

  line_data_feeder dut (
    .clk              (clk),
    .rst              (rst),
    .i_conf_ctrl      (i_conf_ctrl),
    .i_conf_base_addr (i_conf_base_addr),
    .i_conf_num_words (i_conf_num_words),
    .i_data_req       (i_data_req),
    .o_data           (o_data),
    .o_data_val       (o_data_val),
    .o_mem_en         (o_mem_en),
    .o_mem_addr       (o_mem_addr),
    .i_mem_data       (i_mem_data),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] data_of(input logic [15:0] a);
    return {a[7:0], a[7:0], a[7:0]} ^ salt;
  endfunction

  // Activation memory with one cycle of read latency.
  always @(posedge clk) if (o_mem_en) i_mem_data <= data_of(o_mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine request pattern generator.
  initial begin
    int phase = 0;
    i_data_req = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (req_mode)
        1:       i_data_req = ((phase % 5) < 3);
        2:       i_data_req = ($urandom_range(0, 3) != 0);
        default: i_data_req = 1'b1;
      endcase
      phase++;
    end
  end

  // Monitor: consumes the scoreboard and checks per-cycle protocol rules.
  always @(negedge clk) begin
    int rel;
    if (rst) begin
      rel = cyc - start_cyc;
      if (o_mem_en) begin
        memen_cnt++;
        check("issue_while_disabled", 32'(i_conf_ctrl[0]), 32'd1);
        if (exp_addr_q.size() == 0) check("unexpected_mem_en", 32'(o_mem_addr), 32'hFFFF_FFFF);
        else check("mem_addr", 32'(o_mem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (o_data_val) begin
        val_cnt++;
        if (first_val < 0) first_val = rel;
        last_val = rel;
        check("pop_while_disabled", 32'(enb_prev), 32'd1);
        if (exp_data_q.size() == 0) check("unexpected_data", 32'(o_data), 32'hFFFF_FFFF);
        else check("data", 32'(o_data), 32'(exp_data_q.pop_front()));
      end
      if (!i_data_req) begin
        if (o_data_val) begin
          low_vals++;
          check("words_after_req_fall", 32'(low_vals <= 1), 32'd1);
        end
      end else begin
        low_vals = 0;
      end
      if (o_done) begin
        done_cnt++;
        done_rel = rel;
      end
      if (o_busy) busy_cnt++;
    end
    enb_prev = i_conf_ctrl[0];
  end

  task automatic start_xfer(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_data_q.push_back(data_of(base + 16'(i)));
      exp_addr_q.push_back(base + 16'(i));
    end
    @(posedge clk); #1;
    memen_cnt = 0; val_cnt = 0; done_cnt = 0; busy_cnt = 0;
    first_val = -1; last_val = -1; done_rel = -1;
    i_conf_base_addr = base;
    i_conf_num_words = 32'(n);
    i_conf_ctrl      = 32'h3;
    start_cyc        = cyc;
    @(posedge clk); #1;
    i_conf_ctrl = 32'h1;
  endtask

  task automatic finish_xfer(input int n);
    int k = 0;
    while (done_cnt == 0 && k < 600) begin
      @(posedge clk);
      k++;
    end
    check("done_seen", 32'(done_cnt != 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("word_count", 32'(val_cnt), 32'(n));
    check("mem_en_count", 32'(memen_cnt), 32'(n));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("data_left", 32'(exp_data_q.size()), 32'd0);
    check("addr_left", 32'(exp_addr_q.size()), 32'd0);
    check("busy_cycles", 32'(busy_cnt), 32'(done_rel));
    if (n == 0) check("done_cycle_empty", 32'(done_rel), 32'd1);
    else check("done_after_last", 32'(done_rel), 32'(last_val + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b0;
    i_conf_ctrl = '0;
    i_conf_base_addr = '0;
    i_conf_num_words = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_val", 32'(o_data_val), 32'd0);
    check("rst_mem_en", 32'(o_mem_en), 32'd0);
    check("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic run with latency measurements.
    start_xfer(16'h0010, 6);
    finish_xfer(6);
    check("first_val_cycle", 32'(first_val), 32'd3);
    check("last_val_cycle", 32'(last_val), 32'd8);
    check("done_cycle", 32'(done_rel), 32'd9);

    start_xfer(16'h0040, 0);
    finish_xfer(0);

    req_mode = 1;
    start_xfer(16'h0100, 12);
    finish_xfer(12);
    req_mode = 0;

    start_xfer(16'hFFFE, 4);
    finish_xfer(4);

    // Enable gap of four cycles, with a start edge inside it.
    start_xfer(16'h0200, 10);
    repeat (2) @(posedge clk);
    #1 i_conf_ctrl = 32'h0;
    @(posedge clk); #1 i_conf_ctrl = 32'h2;
    @(posedge clk); #1 i_conf_ctrl = 32'h0;
    @(posedge clk); #1 i_conf_ctrl = 32'h0;
    @(posedge clk); #1 i_conf_ctrl = 32'h1;
    finish_xfer(10);

    // Reset in the middle of a transfer.
    salt = 24'h5A3C96;
    start_xfer(16'h0300, 12);
    k = 0;
    while (val_cnt < 2 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("reached_two_words", 32'(val_cnt >= 2), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_data", 32'(o_data), 32'd0);
    check("midrst_val", 32'(o_data_val), 32'd0);
    check("midrst_mem_en", 32'(o_mem_en), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    exp_data_q.delete();
    exp_addr_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_reset", 32'(done_cnt), 32'd0);
    start_xfer(16'h0300, 5);
    finish_xfer(5);

    // Randomised transfers with a random request pattern.
    req_mode = 2;
    for (int t = 0; t < 6; t++) begin
      salt = 24'($urandom);
      start_xfer(16'($urandom), $urandom_range(1, 16));
      finish_xfer(int'(i_conf_num_words));
    end
    req_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
